rc4_ctrl: RTL and testbench

RC4_CTRL -- requirements
Module: rc4_ctrl

---
 rtl/rc4_pkg.sv | 26 ++
 rtl/rc4_ctrl_if.sv | 40 ++++
 rtl/rc4_key_regfile.sv | 34 +++
 rtl/rc4_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_rc4_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and sizes for the RC4 keystream controller.
//   SBOX_SIZE/KEY_MAX size the permutation table and key store;
//   state_e enumerates the controller FSM states.
package rc4_pkg;

    localparam int unsigned SBOX_SIZE = 256;
    localparam int unsigned KEY_MAX   = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned IDX_W     = $clog2(SBOX_SIZE);
    localparam int unsigned KEY_AW    = $clog2(KEY_MAX);

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [DATA_W-1:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA_RD,
        ST_KSA_SW,
        ST_PRGA_RD,
        ST_PRGA_SW,
        ST_PRGA_OUT,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/rc4_ctrl_if.sv
// rc4_ctrl_if: key load, control, keystream handshake and S-box RAM ports.
//   master: environment side (drives key/control/ready, returns RAM read data)
//   slave : controller side (drives status, keystream and RAM addr/data/wen)
interface rc4_ctrl_if;
    import rc4_pkg::*;

    logic              key_wr_en;
    logic [KEY_AW-1:0] key_wr_addr;
    byte_t             key_wr_data;
    logic [KEY_AW-1:0] key_len_m1;
    logic              start;
    logic              abort;
    logic              busy;
    byte_t             ks_data;
    logic              ks_valid;
    logic              ks_ready;
    logic              ram_wen;
    idx_t              ram_raddr_1;
    idx_t              ram_waddr_2;
    byte_t             ram_wdata_2;
    idx_t              ram_addr_3;
    byte_t             ram_wdata_3;
    byte_t             ram_rdata_1;
    byte_t             ram_rdata_3;

    modport master (
        output key_wr_en, key_wr_addr, key_wr_data, key_len_m1, start, abort, ks_ready,
        output ram_rdata_1, ram_rdata_3,
        input  busy, ks_data, ks_valid,
        input  ram_wen, ram_raddr_1, ram_waddr_2, ram_wdata_2, ram_addr_3, ram_wdata_3
    );

    modport slave (
        input  key_wr_en, key_wr_addr, key_wr_data, key_len_m1, start, abort, ks_ready,
        input  ram_rdata_1, ram_rdata_3,
        output busy, ks_data, ks_valid,
        output ram_wen, ram_raddr_1, ram_waddr_2, ram_wdata_2, ram_addr_3, ram_wdata_3
    );

endinterface

// File: rtl/rc4_key_regfile.sv
// rc4_key_regfile: KEY_MAX x 8 key store, synchronous write, asynchronous read.
//   clk/rst_n : clock, synchronous active-low reset (clears all bytes)
//   we/waddr/wdata : write port;  raddr/rdata : combinational read port
module rc4_key_regfile
    import rc4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [KEY_AW-1:0] waddr,
    input  byte_t             wdata,
    input  logic [KEY_AW-1:0] raddr,
    output byte_t             rdata
);

    byte_t mem_q [KEY_MAX];
    byte_t mem_d [KEY_MAX];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(KEY_MAX); k++) mem_q[k] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rc4_ctrl.sv
// rc4_ctrl: RC4 controller driving an external 3-port S-box RAM
// (port 1 read-only, port 2 write-only, port 3 read/write, async reads).
//   clk/rst_n : clock, synchronous active-low reset
//   bus       : key load, start/abort, busy, ks_data/ks_valid/ks_ready, RAM ports
// RAM address/data/wen are combinational from state so a read and the
// dependent swap complete in one cycle each; they are forced to 0 in reset.
module rc4_ctrl
    import rc4_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    rc4_ctrl_if.slave    bus
);

    state_e            state_q, state_d;
    idx_t              i_q, i_d, j_q, j_d, si_q, si_d, t_q, t_d;
    logic [KEY_AW-1:0] kidx_q, kidx_d, klen_q, klen_d;
    byte_t             ks_data_q, ks_data_d;
    logic              ks_valid_q, ks_valid_d;

    idx_t  jn_c, raddr1_c, waddr2_c, addr3_c;
    byte_t wdata2_c, wdata3_c, key_byte_c;
    logic  wen_c, key_we_c;

    // Key bytes may only change while idle.
    assign key_we_c = (state_q == ST_IDLE) && bus.key_wr_en;

    rc4_key_regfile u_key (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (key_we_c),
        .waddr (bus.key_wr_addr),
        .wdata (bus.key_wr_data),
        .raddr (kidx_q),
        .rdata (key_byte_c)
    );

    // RAM addresses and write enable depend only on flops, never on read data.
    always_comb begin
        jn_c     = '0;
        wen_c    = 1'b0;
        raddr1_c = '0;
        waddr2_c = '0;
        addr3_c  = '0;
        case (state_q)
            ST_INIT: begin
                wen_c    = 1'b1;
                waddr2_c = {i_q[IDX_W-2:0], 1'b0};
                addr3_c  = {i_q[IDX_W-2:0], 1'b1};
            end
            ST_KSA_RD:   raddr1_c = i_q;
            ST_KSA_SW: begin
                jn_c     = j_q + si_q + key_byte_c;
                wen_c    = 1'b1;
                waddr2_c = i_q;
                addr3_c  = jn_c;
            end
            ST_PRGA_RD:  raddr1_c = i_q + IDX_W'(1);
            ST_PRGA_SW: begin
                jn_c     = j_q + si_q;
                wen_c    = 1'b1;
                waddr2_c = i_q;
                addr3_c  = jn_c;
            end
            ST_PRGA_OUT: raddr1_c = t_q;
            default: ;
        endcase
        if (!rst_n) begin
            wen_c    = 1'b0;
            raddr1_c = '0;
            waddr2_c = '0;
            addr3_c  = '0;
        end
    end

    // Next state, index updates, swap data and keystream output.
    // When i == jn both ports carry S[i], so the double write is benign.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        t_d        = t_q;
        kidx_d     = kidx_q;
        klen_d     = klen_q;
        ks_data_d  = ks_data_q;
        ks_valid_d = ks_valid_q;
        wdata2_c   = '0;
        wdata3_c   = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_INIT;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    klen_d  = bus.key_len_m1;
                end
            end
            ST_INIT: begin
                wdata2_c = waddr2_c;
                wdata3_c = addr3_c;
                if (i_q == IDX_W'(SBOX_SIZE / 2 - 1)) begin
                    state_d = ST_KSA_RD;
                    i_d     = '0;
                    kidx_d  = '0;
                end else begin
                    i_d = i_q + IDX_W'(1);
                end
            end
            ST_KSA_RD: begin
                si_d    = bus.ram_rdata_1;
                state_d = ST_KSA_SW;
            end
            ST_KSA_SW: begin
                wdata2_c = bus.ram_rdata_3;
                wdata3_c = si_q;
                j_d      = jn_c;
                i_d      = i_q + IDX_W'(1);
                // Running key index avoids a divider for i mod key length.
                kidx_d   = (kidx_q == klen_q) ? '0 : kidx_q + KEY_AW'(1);
                if (i_q == IDX_W'(SBOX_SIZE - 1)) begin
                    state_d = ST_PRGA_RD;
                    i_d     = '0;
                    j_d     = '0;
                end else begin
                    state_d = ST_KSA_RD;
                end
            end
            ST_PRGA_RD: begin
                i_d     = i_q + IDX_W'(1);
                si_d    = bus.ram_rdata_1;
                state_d = ST_PRGA_SW;
            end
            ST_PRGA_SW: begin
                wdata2_c = bus.ram_rdata_3;
                wdata3_c = si_q;
                t_d      = si_q + bus.ram_rdata_3;
                j_d      = jn_c;
                state_d  = ST_PRGA_OUT;
            end
            ST_PRGA_OUT: begin
                ks_data_d  = bus.ram_rdata_1;
                ks_valid_d = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (ks_valid_q && bus.ks_ready) begin
                    ks_valid_d = 1'b0;
                    state_d    = ST_PRGA_RD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort outranks start and ks_ready.
        if (bus.abort) begin
            state_d    = ST_IDLE;
            ks_valid_d = 1'b0;
        end
        if (!rst_n) begin
            wdata2_c = '0;
            wdata3_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            si_q       <= '0;
            t_q        <= '0;
            kidx_q     <= '0;
            klen_q     <= '0;
            ks_data_q  <= '0;
            ks_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            si_q       <= si_d;
            t_q        <= t_d;
            kidx_q     <= kidx_d;
            klen_q     <= klen_d;
            ks_data_q  <= ks_data_d;
            ks_valid_q <= ks_valid_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.ks_data     = ks_data_q;
    assign bus.ks_valid    = ks_valid_q;
    assign bus.ram_wen     = wen_c;
    assign bus.ram_raddr_1 = raddr1_c;
    assign bus.ram_waddr_2 = waddr2_c;
    assign bus.ram_wdata_2 = wdata2_c;
    assign bus.ram_addr_3  = addr3_c;
    assign bus.ram_wdata_3 = wdata3_c;

endmodule

// File: tb/tb_rc4_ctrl.sv
// tb_rc4_ctrl: directed bench for rc4_ctrl with a behavioural 3-port S-box RAM.
// Cycle c is the c-th clock period after the edge that samples start; outputs
// are sampled at the falling edge of each period.
module tb_rc4_ctrl;
    import rc4_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [7:0] sbox [256];

    rc4_ctrl_if bus ();

    rc4_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_wen) begin
            sbox[bus.ram_waddr_2] <= bus.ram_wdata_2;
            sbox[bus.ram_addr_3]  <= bus.ram_wdata_3;
        end
    end

    assign bus.ram_rdata_1 = sbox[bus.ram_raddr_1];
    assign bus.ram_rdata_3 = sbox[bus.ram_addr_3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit perm_ok();
        bit seen [256];
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        for (int k = 0; k < 256; k++) begin
            if ($isunknown(sbox[k])) ok = 1'b0;
            else if (seen[sbox[k]]) ok = 1'b0;
            else seen[sbox[k]] = 1'b1;
        end
        return ok;
    endfunction

    task automatic load_key(input logic [127:0] key, input int len);
        for (int b = 0; b < len; b++) begin
            @(negedge clk);
            bus.key_wr_en   = 1'b1;
            bus.key_wr_addr = 4'(b);
            bus.key_wr_data = key[8*(len-1-b) +: 8];
        end
        @(negedge clk);
        bus.key_wr_en  = 1'b0;
        bus.key_len_m1 = 4'(len - 1);
    endtask

    // Start a run, check every cycle, abort at the last cycle.
    // h: cycles ks_ready stays low while the first byte is held.
    // poke_c: cycle at which start and a key write are attempted while busy.
    // abort_c: early abort cycle (0 = after the n-th byte).
    task automatic run_ks(input string name, input logic [127:0] exp, input int n,
                          input int h, input int poke_c, input int abort_c);
        int   last;
        int   vk;
        logic ev, ew;
        bit   init_ok, ksa_ok, wen_ok, valid_ok, perm_all, busy_ok;
        last     = (abort_c > 0) ? abort_c : 644 + h + 4 * (n - 1);
        init_ok  = 1'b1;
        ksa_ok   = 1'b1;
        wen_ok   = 1'b1;
        valid_ok = 1'b1;
        perm_all = 1'b1;
        busy_ok  = 1'b1;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.ks_ready = 1'b0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (poke_c > 0 && c == poke_c + 1) begin
                bus.start     = 1'b0;
                bus.key_wr_en = 1'b0;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (c <= 128) begin
                ew = 1'b1;
                if (bus.ram_waddr_2 !== 8'(2 * (c - 1)) || bus.ram_wdata_2 !== 8'(2 * (c - 1)) ||
                    bus.ram_addr_3 !== 8'(2 * c - 1) || bus.ram_wdata_3 !== 8'(2 * c - 1))
                    init_ok = 1'b0;
            end else if (c <= 640) begin
                ew = ((c - 128) % 2 == 0);
                if (ew && bus.ram_waddr_2 !== 8'((c - 130) / 2)) ksa_ok = 1'b0;
            end else begin
                ew = (c == 642) || (c > 644 + h && (c - 644 - h) % 4 == 2);
            end
            if (bus.ram_wen !== ew) wen_ok = 1'b0;
            if (c >= 129 && !perm_ok()) perm_all = 1'b0;
            ev = (c >= 644 && c <= 644 + h) || (c > 644 + h && (c - 644 - h) % 4 == 0);
            if (bus.ks_valid !== ev) valid_ok = 1'b0;
            if (c == 643) chk($sformatf("%s valid_low_c643", name), 32'(bus.ks_valid), 32'd0);
            if (c == 644) chk($sformatf("%s first_valid_c644", name), 32'(bus.ks_valid), 32'd1);
            if (ev && n > 0) begin
                vk = (c <= 644 + h) ? 0 : (c - 644 - h) / 4;
                chk($sformatf("%s ks[%0d] c%0d", name, vk, c), 32'(bus.ks_data),
                    32'(exp[8*(n-1-vk) +: 8]));
            end
            bus.ks_ready = (c >= 644 + h);
            if (c == poke_c) begin
                bus.start       = 1'b1;
                bus.key_wr_en   = 1'b1;
                bus.key_wr_addr = 4'd0;
                bus.key_wr_data = 8'hFF;
                bus.key_len_m1  = 4'd15;
            end
            if (c == last) bus.abort = 1'b1;
        end
        chk($sformatf("%s init_pattern", name), 32'(init_ok), 32'd1);
        chk($sformatf("%s ksa_waddr", name), 32'(ksa_ok), 32'd1);
        chk($sformatf("%s wen_pattern", name), 32'(wen_ok), 32'd1);
        chk($sformatf("%s valid_pattern", name), 32'(valid_ok), 32'd1);
        chk($sformatf("%s sbox_perm", name), 32'(perm_all), 32'd1);
        chk($sformatf("%s busy_high", name), 32'(busy_ok), 32'd1);
        @(negedge clk);
        bus.abort    = 1'b0;
        bus.ks_ready = 1'b0;
        chk($sformatf("%s abort_busy", name), 32'(bus.busy), 32'd0);
        chk($sformatf("%s abort_valid", name), 32'(bus.ks_valid), 32'd0);
        chk($sformatf("%s abort_wen", name), 32'(bus.ram_wen), 32'd0);
    endtask

    initial begin
        tests           = 0;
        fails           = 0;
        rst_n           = 1'b0;
        bus.key_wr_en   = 1'b0;
        bus.key_wr_addr = '0;
        bus.key_wr_data = '0;
        bus.key_len_m1  = '0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.ks_ready    = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst ks_valid", 32'(bus.ks_valid), 32'd0);
        chk("rst ks_data", 32'(bus.ks_data), 32'd0);
        chk("rst ram_wen", 32'(bus.ram_wen), 32'd0);
        chk("rst addrs", 32'({bus.ram_raddr_1, bus.ram_waddr_2, bus.ram_addr_3}), 32'd0);
        chk("rst wdata", 32'({bus.ram_wdata_2, bus.ram_wdata_3}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", 32'(bus.busy), 32'd0);

        // Abort outranks start in IDLE.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort_over_start busy", 32'(bus.busy), 32'd0);

        load_key(128'h4B6579, 3);
        run_ks("key", 128'hEB9F7781B734CA72A719, 10, 0, 0, 0);

        load_key(128'h57696B69, 4);
        run_ks("wiki", 128'h6044DB6D41B7, 6, 0, 0, 0);

        load_key(128'h536563726574, 6);
        run_ks("secret", 128'h04D46B053CA87B59, 8, 20, 300, 0);

        // Abort in KSA_SW over a partly permuted table, then a fresh "Key" run.
        load_key(128'h57696B69, 4);
        run_ks("wiki_abort", 128'h0, 0, 0, 0, 130);
        load_key(128'h4B6579, 3);
        run_ks("key_again", 128'hEB9F7781B734CA72A719, 10, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
